// File: rtl/int8_q428_unpacker_pkg.sv
// Shared constants and types for the int8 -> Q4.28 dequantizing unpacker.
package int8_q428_unpacker_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned LANE_W    = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned FUNC_ID_W = 10;

  localparam logic [FUNC_ID_W-1:0] FUNC_SET  = 10'd2;
  localparam logic [FUNC_ID_W-1:0] FUNC_PUSH = 10'd3;

  localparam logic [DATA_W-1:0] Q428_ONE = 32'h1000_0000;
  localparam logic [DATA_W-1:0] Q428_MAX = 32'h7fff_ffff;
  localparam logic [DATA_W-1:0] Q428_MIN = 32'h8000_0000;

  typedef enum logic [0:0] {
    StIdle,
    StDrain
  } state_e;

endpackage

// File: rtl/int8_q428_unpacker_if.sv
// Command and sample stream bundle between a CFU-style host and the unpacker.
interface int8_q428_unpacker_if;
  import int8_q428_unpacker_pkg::*;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [FUNC_ID_W-1:0] cmd_payload_function_id;
  logic [DATA_W-1:0]    cmd_payload_inputs_0;
  logic [DATA_W-1:0]    cmd_payload_inputs_1;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;

  modport master (
    output cmd_valid,
    input  cmd_ready,
    output cmd_payload_function_id,
    output cmd_payload_inputs_0,
    output cmd_payload_inputs_1,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  cmd_valid,
    output cmd_ready,
    input  cmd_payload_function_id,
    input  cmd_payload_inputs_0,
    input  cmd_payload_inputs_1,
    output out_valid,
    input  out_ready,
    output out_data
  );

endinterface

// File: rtl/int8_q428_unpacker_lane_scale.sv
// Combinational dequantizer: (q - zero_point) * scale, saturated to Q4.28.
module q428_lane_scale
  import int8_q428_unpacker_pkg::*;
#(
  parameter int unsigned LaneW = LANE_W
) (
  input  logic [LaneW-1:0]  lane,
  input  logic [LaneW-1:0]  zp,
  input  logic [DATA_W-1:0] scale,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned DiffW = LaneW + 1;
  localparam int unsigned ProdW = DiffW + DATA_W;

  localparam logic signed [ProdW-1:0] MaxExt = {{(ProdW - DATA_W){1'b0}}, Q428_MAX};
  localparam logic signed [ProdW-1:0] MinExt = {{(ProdW - DATA_W){1'b1}}, Q428_MIN};

  logic signed [DiffW-1:0] diff;
  logic signed [ProdW-1:0] diff_ext;
  logic signed [ProdW-1:0] scale_ext;
  logic signed [ProdW-1:0] prod;

  assign diff      = $signed({lane[LaneW-1], lane}) - $signed({zp[LaneW-1], zp});
  assign diff_ext  = {{(ProdW - DiffW){diff[DiffW-1]}}, diff};
  assign scale_ext = {{(ProdW - DATA_W){scale[DATA_W-1]}}, scale};
  // diff is an integer and scale is Q4.28, so the product is already Q4.28.
  assign prod      = diff_ext * scale_ext;

  always_comb begin
    result = prod[DATA_W-1:0];
    if (prod > MaxExt) begin
      result = Q428_MAX;
    end else if (prod < MinExt) begin
      result = Q428_MIN;
    end
  end

endmodule

// File: rtl/int8_q428_unpacker.sv
// Accepts packed int8 words and streams one dequantized Q4.28 sample per lane.
module int8_q428_unpacker
  import int8_q428_unpacker_pkg::*;
#(
  parameter int unsigned          Lanes    = LANES,
  parameter int unsigned          LaneW    = LANE_W,
  parameter logic [FUNC_ID_W-1:0] FuncSet  = FUNC_SET,
  parameter logic [FUNC_ID_W-1:0] FuncPush = FUNC_PUSH
) (
  input  logic                 clk,
  input  logic                 reset,
  int8_q428_unpacker_if.slave  bus,
  output logic                 busy
);

  localparam int unsigned IdxW    = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Lanes - 1);

  state_e                state_q;
  logic [IdxW-1:0]       idx_q;
  logic [LaneW-1:0]      lanes_q [Lanes];
  logic [LaneW-1:0]      zp_q;
  logic [DATA_W-1:0]     scale_q;
  logic                  out_valid_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [DATA_W-1:0]     lane_result;

  q428_lane_scale #(
    .LaneW (LaneW)
  ) u_lane_scale (
    .lane   (lanes_q[idx_q]),
    .zp     (zp_q),
    .scale  (scale_q),
    .result (lane_result)
  );

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      zp_q        <= '0;
      scale_q     <= Q428_ONE;
    end else begin
      // A load later in this block overrides the clear on a back-to-back transfer.
      if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_payload_function_id == FuncSet) begin
              zp_q    <= bus.cmd_payload_inputs_0[LaneW-1:0];
              scale_q <= bus.cmd_payload_inputs_1;
            end else if (bus.cmd_payload_function_id == FuncPush) begin
              for (int i = 0; i < int'(Lanes); i++) begin
                lanes_q[i] <= bus.cmd_payload_inputs_0[i*LaneW +: LaneW];
              end
              idx_q   <= '0;
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (!out_valid_q || bus.out_ready) begin
            out_data_q  <= lane_result;
            out_valid_q <= 1'b1;
            if (idx_q == LastIdx) begin
              idx_q   <= '0;
              state_q <= StIdle;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_int8_q428_unpacker.sv
// Directed bench for int8_q428_unpacker with hand-computed Q4.28 expectations.
module tb_int8_q428_unpacker;
  import int8_q428_unpacker_pkg::*;

  typedef logic [0:3][31:0] exp4_t;

  logic clk;
  logic reset;
  logic busy;
  int   n_tests;
  int   n_fail;

  int8_q428_unpacker_if bus ();

  int8_q428_unpacker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1);
    int n = 0;
    bus.cmd_valid               = 1'b1;
    bus.cmd_payload_function_id = fid;
    bus.cmd_payload_inputs_0    = in0;
    bus.cmd_payload_inputs_1    = in1;
    while (!bus.cmd_ready && n < 20) begin
      step();
      n++;
    end
    check_val("cmd_accept_in_time", 32'(n < 20), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
  endtask

  // Push one word with out_ready held high and expect four back-to-back samples.
  task automatic push_and_drain(input string tag, input logic [31:0] word, input exp4_t exp);
    send_cmd(FUNC_PUSH, word, 32'h0);
    check_val({tag, "_busy_after_push"}, 32'(busy), 32'd1);
    check_val({tag, "_valid_e0"}, 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_valid%0d", tag, i), 32'(bus.out_valid), 32'd1);
      check_val($sformatf("%s_data%0d", tag, i), bus.out_data, exp[i]);
      if (i == 3) begin
        check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
        check_val({tag, "_ready_end"}, 32'(bus.cmd_ready), 32'd1);
      end
      step();
    end
    check_val({tag, "_valid_clear"}, 32'(bus.out_valid), 32'd0);
  endtask

  exp4_t exp_t1;
  exp4_t exp_t2;
  exp4_t exp_t4;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_t1  = {32'hF000_0000, 32'h1000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    // Lane 0 of 0x7F008000 is 0x00: (0 - (-128)) * 2^-8 = 0.5.
    exp_t2  = {32'h0800_0000, 32'h0000_0000, 32'h0800_0000, 32'h0FF0_0000};
    // zp=5, scale=2.0 on lanes 6,5,4,8.
    exp_t4  = {32'h2000_0000, 32'h0000_0000, 32'hE000_0000, 32'h6000_0000};

    bus.cmd_valid               = 1'b0;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0    = '0;
    bus.cmd_payload_inputs_1    = '0;
    bus.out_ready               = 1'b0;
    reset                       = 1'b1;
    step();
    step();
    reset = 1'b0;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_data", bus.out_data, 32'h0);
    check_val("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_val("rst_busy", 32'(busy), 32'd0);

    // Test 1: unity config, full signed range with saturation.
    send_cmd(FUNC_SET, 32'h0000_0000, 32'h1000_0000);
    push_and_drain("t1", 32'h807F_01FF, exp_t1);

    // Test 2: zp=-128, small scale.
    send_cmd(FUNC_SET, 32'h0000_0080, 32'h0010_0000);
    push_and_drain("t2", 32'h7F00_8000, exp_t2);

    // Test 3: downstream stall on lane 1.
    send_cmd(FUNC_SET, 32'h0000_0000, 32'h1000_0000);
    send_cmd(FUNC_PUSH, 32'h807F_01FF, 32'h0);
    bus.out_ready = 1'b1;
    step();
    check_val("t3_data0", bus.out_data, exp_t1[0]);
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("t3_hold_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check_val($sformatf("t3_hold_data%0d", i), bus.out_data, exp_t1[1]);
      check_val($sformatf("t3_hold_busy%0d", i), 32'(busy), 32'd1);
      step();
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check_val($sformatf("t3_valid%0d", i), 32'(bus.out_valid), 32'd1);
      check_val($sformatf("t3_data%0d", i), bus.out_data, exp_t1[i]);
      step();
    end
    check_val("t3_valid_clear", 32'(bus.out_valid), 32'd0);

    // Test 4: SET held during a drain must wait for IDLE.
    send_cmd(FUNC_PUSH, 32'h807F_01FF, 32'h0);
    bus.cmd_valid               = 1'b1;
    bus.cmd_payload_function_id = FUNC_SET;
    bus.cmd_payload_inputs_0    = 32'h0000_0005;
    bus.cmd_payload_inputs_1    = 32'h2000_0000;
    step();
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("t4_cmd_ready%0d", i), 32'(bus.cmd_ready), 32'(i == 3));
      check_val($sformatf("t4_data%0d", i), bus.out_data, exp_t1[i]);
      step();
    end
    bus.cmd_valid = 1'b0;
    check_val("t4_idle_after_set", 32'(busy), 32'd0);
    push_and_drain("t4_new_cfg", 32'h0804_0506, exp_t4);

    // Test 5: reset mid-drain discards remaining lanes and restores defaults.
    send_cmd(FUNC_PUSH, 32'h807F_01FF, 32'h0);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("t5_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("t5_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_val("t5_busy", 32'(busy), 32'd0);
    step();
    check_val("t5_no_stray_valid", 32'(bus.out_valid), 32'd0);
    push_and_drain("t5_defaults", 32'h807F_01FF, exp_t1);

    // Test 6: unknown id is swallowed without side effects.
    send_cmd(10'd7, 32'h0000_0011, 32'h1234_5678);
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("t6_valid%0d", i), 32'(bus.out_valid), 32'd0);
      check_val($sformatf("t6_busy%0d", i), 32'(busy), 32'd0);
      step();
    end
    push_and_drain("t6", 32'h807F_01FF, exp_t1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
